id_exe_stage_reg: RTL and testbench

//  Pipeline register between Instruction Decode and Execute. Captures decoded

---
 rtl/id_exe_stage_reg.sv | 72 +++++++
 tb/tb_id_exe_stage_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with freeze, flush bubble and saturating stall counter.
// Control bits are gated to zero for bubbles; datapath is zeroed on flush and loaded otherwise.
module id_exe_stage_reg #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [WIDTH-1:0]   id_pc,
  input  logic [WIDTH-1:0]   id_val_rn,
  input  logic [WIDTH-1:0]   id_val_rm,
  input  logic [11:0]        id_shift_operand,
  input  logic               id_imm,
  input  logic [23:0]        id_signed_imm24,
  input  logic [RADDR_W-1:0] id_dest,
  input  logic [RADDR_W-1:0] id_src1,
  input  logic [RADDR_W-1:0] id_src2,
  input  logic [3:0]         id_exe_cmd,
  input  logic               id_mem_r_en,
  input  logic               id_mem_w_en,
  input  logic               id_wb_en,
  input  logic               id_b,
  input  logic               id_s,
  input  logic               id_sr_c,
  output logic               ex_valid,
  output logic [WIDTH-1:0]   ex_pc,
  output logic [WIDTH-1:0]   ex_val_rn,
  output logic [WIDTH-1:0]   ex_val_rm,
  output logic [11:0]        ex_shift_operand,
  output logic               ex_imm,
  output logic [23:0]        ex_signed_imm24,
  output logic [RADDR_W-1:0] ex_dest,
  output logic [RADDR_W-1:0] ex_src1,
  output logic [RADDR_W-1:0] ex_src2,
  output logic [3:0]         ex_exe_cmd,
  output logic               ex_mem_r_en,
  output logic               ex_mem_w_en,
  output logic               ex_wb_en,
  output logic               ex_b,
  output logic               ex_s,
  output logic               ex_sr_c,
  output logic               ex_mem,
  output logic [CNT_W-1:0]   stall_cnt
);
  localparam int DW = 3*WIDTH + 12 + 1 + 24 + 3*RADDR_W + 4 + 1;
  logic [DW-1:0] data;
  logic [6:0]    ctl;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data      <= '0;
      ctl       <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        data <= '0;
        ctl  <= '0;
      end else if (!freeze) begin
        data <= {id_pc, id_val_rn, id_val_rm, id_shift_operand, id_imm, id_signed_imm24,
                 id_dest, id_src1, id_src2, id_exe_cmd, id_sr_c};
        ctl  <= id_valid ? {1'b1, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s,
                            id_mem_r_en | id_mem_w_en} : 7'b0;
      end
      if (freeze && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  assign {ex_pc, ex_val_rn, ex_val_rm, ex_shift_operand, ex_imm, ex_signed_imm24,
          ex_dest, ex_src1, ex_src2, ex_exe_cmd, ex_sr_c} = data;
  assign {ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_mem} = ctl;
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb_id_exe_stage_reg: directed and random checks of id_exe_stage_reg against a field-level model.
module tb_id_exe_stage_reg;
  logic clk = 1'b0, rst_n = 1'b0, freeze = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_val_rn = '0, id_val_rm = '0;
  logic [11:0] id_shift_operand = '0;
  logic id_imm = 1'b0, id_mem_r_en = 1'b0, id_mem_w_en = 1'b0, id_wb_en = 1'b0;
  logic id_b = 1'b0, id_s = 1'b0, id_sr_c = 1'b0;
  logic [23:0] id_signed_imm24 = '0;
  logic [3:0] id_dest = '0, id_src1 = '0, id_src2 = '0, id_exe_cmd = '0;
  logic ex_valid, ex_imm, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_b, ex_s, ex_sr_c, ex_mem;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [11:0] ex_shift_operand;
  logic [23:0] ex_signed_imm24;
  logic [3:0] ex_dest, ex_src1, ex_src2, ex_exe_cmd, stall_cnt;

  id_exe_stage_reg #(.WIDTH(32), .RADDR_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
    .id_shift_operand(id_shift_operand), .id_imm(id_imm), .id_signed_imm24(id_signed_imm24),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_exe_cmd(id_exe_cmd),
    .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en),
    .id_b(id_b), .id_s(id_s), .id_sr_c(id_sr_c),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm),
    .ex_shift_operand(ex_shift_operand), .ex_imm(ex_imm), .ex_signed_imm24(ex_signed_imm24),
    .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_exe_cmd(ex_exe_cmd),
    .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en), .ex_wb_en(ex_wb_en),
    .ex_b(ex_b), .ex_s(ex_s), .ex_sr_c(ex_sr_c), .ex_mem(ex_mem), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic valid;
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic imm;
    logic [23:0] imm24;
    logic [3:0] dest, src1, src2, cmd;
    logic mr, mw, wb, b, s, c, mem;
  } st_t;

  st_t m = '0;
  logic [3:0] mcnt = '0;
  int compared = 0, mismatched = 0;

  function automatic st_t dut_out();
    st_t o;
    o.valid = ex_valid; o.pc = ex_pc; o.rn = ex_val_rn; o.rm = ex_val_rm;
    o.sh = ex_shift_operand; o.imm = ex_imm; o.imm24 = ex_signed_imm24;
    o.dest = ex_dest; o.src1 = ex_src1; o.src2 = ex_src2; o.cmd = ex_exe_cmd;
    o.mr = ex_mem_r_en; o.mw = ex_mem_w_en; o.wb = ex_wb_en; o.b = ex_b; o.s = ex_s;
    o.c = ex_sr_c; o.mem = ex_mem;
    return o;
  endfunction

  // Expected stage contents after a load: a copy of ID, with a bubble's controls all zero.
  function automatic st_t loaded();
    st_t o;
    o.valid = id_valid; o.pc = id_pc; o.rn = id_val_rn; o.rm = id_val_rm;
    o.sh = id_shift_operand; o.imm = id_imm; o.imm24 = id_signed_imm24;
    o.dest = id_dest; o.src1 = id_src1; o.src2 = id_src2; o.cmd = id_exe_cmd;
    o.c = id_sr_c;
    o.mr = id_valid & id_mem_r_en; o.mw = id_valid & id_mem_w_en;
    o.wb = id_valid & id_wb_en; o.b = id_valid & id_b; o.s = id_valid & id_s;
    o.mem = id_valid & (id_mem_r_en | id_mem_w_en);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    st_t o;
    o = dut_out();
    compared++;
    assert (o === m) else begin
      mismatched++;
      $error("FAIL %s stage observed=%h expected=%h", tag, o, m);
    end
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(mcnt));
  endtask

  task automatic rand_in();
    id_valid = ($urandom % 4) != 0;
    id_pc = $urandom; id_val_rn = $urandom; id_val_rm = $urandom;
    id_shift_operand = 12'($urandom); id_imm = 1'($urandom);
    id_signed_imm24 = 24'($urandom);
    id_dest = 4'($urandom); id_src1 = 4'($urandom); id_src2 = 4'($urandom);
    id_exe_cmd = 4'($urandom);
    id_mem_r_en = 1'($urandom); id_mem_w_en = 1'($urandom); id_wb_en = 1'($urandom);
    id_b = 1'($urandom); id_s = 1'($urandom); id_sr_c = 1'($urandom);
  endtask

  task automatic clear_in();
    id_valid = 1'b1; id_pc = '0; id_val_rn = '0; id_val_rm = '0; id_shift_operand = '0;
    id_imm = 1'b0; id_signed_imm24 = '0; id_dest = '0; id_src1 = '0; id_src2 = '0;
    id_exe_cmd = '0; id_mem_r_en = 1'b0; id_mem_w_en = 1'b0; id_wb_en = 1'b0;
    id_b = 1'b0; id_s = 1'b0; id_sr_c = 1'b0;
  endtask

  // Inputs only change 1 time unit after an edge, so they are stable here.
  task automatic step(input string tag);
    @(posedge clk);
    if (flush) m = '0;
    else if (freeze) mcnt = (mcnt == 4'hF) ? mcnt : mcnt + 4'd1;
    else m = loaded();
    #1 chk_all(tag);
  endtask

  initial begin
    #2 chk_all("reset_init");
    #1 rst_n = 1'b1;
    clear_in();
    id_pc = 32'h10; id_wb_en = 1'b1;
    step("load_pc");
    chk("load_pc.ex_pc", ex_pc, 32'h10);
    chk("load_pc.ex_wb_en", 32'(ex_wb_en), 32'd1);
    #2 rst_n = 1'b0;
    m = '0; mcnt = '0;
    #1 chk_all("async_reset");
    chk("async_reset.ex_pc", ex_pc, 32'h0);
    rst_n = 1'b1;

    clear_in();
    id_val_rm = 32'hDEADBEEF; id_shift_operand = 12'h0A3; id_mem_r_en = 1'b1;
    step("load_rm");
    chk("load_rm.ex_val_rm", ex_val_rm, 32'hDEADBEEF);
    chk("load_rm.ex_shift_operand", 32'(ex_shift_operand), 32'h0A3);
    chk("load_rm.ex_mem", 32'(ex_mem), 32'd1);

    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      step("freeze");
      chk("freeze.ex_val_rm", ex_val_rm, 32'hDEADBEEF);
    end
    chk("freeze.stall_cnt", 32'(stall_cnt), 32'd3);
    freeze = 1'b0;
    rand_in();
    step("unfreeze");
    chk("unfreeze.ex_pc", ex_pc, id_pc);

    clear_in();
    id_wb_en = 1'b1; freeze = 1'b1; flush = 1'b1;
    step("flush_frozen");
    chk("flush_frozen.ex_wb_en", 32'(ex_wb_en), 32'd0);
    chk("flush_frozen.ex_valid", 32'(ex_valid), 32'd0);
    chk("flush_frozen.stall_cnt", 32'(stall_cnt), 32'd3);
    freeze = 1'b0; flush = 1'b0;

    clear_in();
    id_valid = 1'b0; id_mem_w_en = 1'b1; id_b = 1'b1; id_pc = 32'h44;
    step("bubble");
    chk("bubble.ex_mem_w_en", 32'(ex_mem_w_en), 32'd0);
    chk("bubble.ex_b", 32'(ex_b), 32'd0);
    chk("bubble.ex_mem", 32'(ex_mem), 32'd0);

    freeze = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_in();
      step("saturate");
    end
    chk("saturate.stall_cnt", 32'(stall_cnt), 32'd15);
    freeze = 1'b0;

    for (int i = 0; i < 300; i++) begin
      rand_in();
      freeze = ($urandom % 4) == 0;
      flush = ($urandom % 8) == 0;
      step("random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
